alu_seq_ctrl: RTL and testbench

Sequencing controller for the 8-bit accumulator ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's optype, opcode, operand and carry-in inputs. It chains two ALU passes for 16-bit ADD/AND/OR/XOR and keeps the architectural Z/C/N flag registers. The block sits between the instruction decode stage and the ALU, and returns the result over a second valid/ready handshake.

---
 rtl/alu_seq_ctrl_if.sv | 26 ++
 rtl/alu_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between decode and the ALU sequencer.
// The master issues requests and consumes results.
interface alu_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_wide;
    logic        req_use_carry;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;

    modport master (
        output req_valid, req_op, req_wide, req_use_carry,
        output req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_wide, req_use_carry,
        input  req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the 8-bit accumulator ALU: chains two passes for 16-bit
// add/and/or/xor and owns the architectural Z/C/N flags.
module alu_seq_ctrl (
    input  logic          clk,
    input  logic          reset_n,
    alu_seq_ctrl_if.slave bus,
    output logic          z_flag,
    output logic          c_flag,
    output logic          n_flag,
    output logic          alu_optype,
    output logic [3:0]    alu_op,
    output logic [7:0]    alu_acc,
    output logic [7:0]    alu_reg,
    output logic          alu_cin,
    input  logic [7:0]    alu_out,
    input  logic          alu_c,
    input  logic          alu_z,
    input  logic          alu_n
);
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CLR = 4'b1011;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  op_q;
    logic        wide_q;
    logic        uc_q;
    logic [15:0] a_q, b_q, res_q;
    logic        ctmp_q;
    logic        accept, wide_ok, last_pass;
    logic        is_add, is_sub, is_cmp, is_clr;

    assign is_add = (op_q == OP_ADD);
    assign is_sub = (op_q == OP_SUB);
    assign is_cmp = (op_q == OP_CMP);
    assign is_clr = (op_q == OP_CLR);

    // Only ops whose bit slices are independent (or carry-chained) go wide.
    always_comb begin
        wide_ok = 1'b0;
        unique case (1'b1)
            bus.req_op == OP_ADD: wide_ok = bus.req_wide;
            bus.req_op == OP_AND: wide_ok = bus.req_wide;
            bus.req_op == OP_OR:  wide_ok = bus.req_wide;
            bus.req_op == OP_XOR: wide_ok = bus.req_wide;
            default:              wide_ok = 1'b0;
        endcase
    end

    assign accept    = (state == IDLE) && bus.req_valid;
    assign last_pass = ((state == LO) && !wide_q) || (state == HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        alu_optype     = 1'b1;
        alu_op         = 4'b0000;
        alu_acc        = 8'h00;
        alu_reg        = 8'h00;
        alu_cin        = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = LO;
            end
            LO: begin
                alu_optype = 1'b0;
                alu_op     = op_q;
                alu_acc    = a_q[7:0];
                alu_reg    = b_q[7:0];
                alu_cin    = is_add ? (uc_q & c_flag) : c_flag;
                state_nx   = wide_q ? HI : RESP;
            end
            HI: begin
                alu_optype = 1'b0;
                alu_op     = op_q;
                alu_acc    = a_q[15:8];
                alu_reg    = b_q[15:8];
                alu_cin    = is_add & ctmp_q;
                state_nx   = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
        endcase
    end

    assign bus.rsp_result = res_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= 4'h0;
            wide_q <= 1'b0;
            uc_q   <= 1'b0;
            a_q    <= 16'h0;
            b_q    <= 16'h0;
            res_q  <= 16'h0;
            ctmp_q <= 1'b0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            n_flag <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= bus.req_op;
                wide_q <= wide_ok;
                uc_q   <= bus.req_use_carry;
                a_q    <= bus.req_a;
                b_q    <= bus.req_b;
            end
            if (state == LO) begin
                res_q  <= (is_cmp || is_clr) ? 16'h0 : {8'h00, alu_out};
                ctmp_q <= alu_c;
            end
            if (state == HI) res_q[15:8] <= alu_out;
            if (last_pass) begin
                if (is_add || is_sub) c_flag <= alu_c;
                if (is_clr)           c_flag <= 1'b0;
                if (is_cmp) begin
                    z_flag <= alu_z;
                    n_flag <= alu_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and random checks of the ALU sequencer against a word-level model.
// A small combinational ALU stands in for the real datapath.
module tb_alu_seq_ctrl;
    logic       clk;
    logic       reset_n;
    logic       z_flag, c_flag, n_flag;
    logic       alu_optype;
    logic [3:0] alu_op;
    logic [7:0] alu_acc, alu_reg;
    logic       alu_cin;
    logic [7:0] alu_out;
    logic       alu_c, alu_z, alu_n;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .z_flag     (z_flag),
        .c_flag     (c_flag),
        .n_flag     (n_flag),
        .alu_optype (alu_optype),
        .alu_op     (alu_op),
        .alu_acc    (alu_acc),
        .alu_reg    (alu_reg),
        .alu_cin    (alu_cin),
        .alu_out    (alu_out),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_n      (alu_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        logic [8:0] s;
        s       = 9'h0;
        alu_out = 8'h00;
        alu_c   = 1'b0;
        case (alu_op)
            4'h2: begin
                s       = {1'b0, alu_acc} + {1'b0, alu_reg} + {8'h0, alu_cin};
                alu_out = s[7:0];
                alu_c   = s[8];
            end
            4'h3: begin
                alu_out = alu_acc - alu_reg;
                alu_c   = alu_acc < alu_reg;
            end
            4'h4: alu_out = alu_acc << alu_reg[2:0];
            4'h5: alu_out = alu_acc >> alu_reg[2:0];
            4'h6: alu_out = alu_acc & alu_reg;
            4'h7: alu_out = alu_acc | alu_reg;
            4'h8: alu_out = alu_acc ^ alu_reg;
            4'h9: alu_out = 8'($countones(alu_reg));
            4'hA: alu_out = alu_acc - alu_reg;
            default: alu_out = 8'h00;
        endcase
        alu_z = (alu_out == 8'h00);
        alu_n = alu_out[7];
    end

    int   n_chk  = 0;
    int   n_pass = 0;
    logic m_z, m_c, m_n;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic is_wide(input logic [3:0] op, input logic w);
        return w && (op == 4'h2 || op == 4'h6 || op == 4'h7 || op == 4'h8);
    endfunction

    task automatic model(input logic [3:0] op, input logic w, input logic uc,
                         input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r);
        int unsigned s;
        logic [7:0]  a8, b8, t;
        logic        ew;
        a8 = a[7:0];
        b8 = b[7:0];
        ew = is_wide(op, w);
        r  = 16'h0;
        case (op)
            4'h2: begin
                if (ew) begin
                    s   = int'(a) + int'(b) + int'(uc & m_c);
                    r   = s[15:0];
                    m_c = s[16];
                end else begin
                    s   = int'(a8) + int'(b8) + int'(uc & m_c);
                    r   = {8'h0, s[7:0]};
                    m_c = s[8];
                end
            end
            4'h3: begin
                t   = a8 - b8;
                r   = {8'h0, t};
                m_c = a8 < b8;
            end
            4'h4: begin t = a8 << b8[2:0]; r = {8'h0, t}; end
            4'h5: begin t = a8 >> b8[2:0]; r = {8'h0, t}; end
            4'h6: r = ew ? (a & b) : {8'h0, a8 & b8};
            4'h7: r = ew ? (a | b) : {8'h0, a8 | b8};
            4'h8: r = ew ? (a ^ b) : {8'h0, a8 ^ b8};
            4'h9: r = 16'($countones(b8));
            4'hA: begin
                t   = a8 - b8;
                m_z = (a8 == b8);
                m_n = t[7];
            end
            4'hB: m_c = 1'b0;
            default: r = 16'h0;
        endcase
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic run(input string tag, input logic [3:0] op, input logic w,
                       input logic uc, input logic [15:0] a,
                       input logic [15:0] b, input int hold);
        logic [15:0] er;
        int          lat;
        model(op, w, uc, a, b, er);
        chk({tag, ".rdy"}, bus.req_ready, 1);
        bus.req_op        = op;
        bus.req_wide      = w;
        bus.req_use_carry = uc;
        bus.req_a         = a;
        bus.req_b         = b;
        bus.rsp_ready     = (hold == 0);
        bus.req_valid     = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, is_wide(op, w) ? 3 : 2);
        chk({tag, ".res"}, bus.rsp_result, er);
        chk({tag, ".flg"}, {z_flag, c_flag, n_flag}, {m_z, m_c, m_n});
        if (hold > 0) begin
            bus.req_valid = 1'b1;
            bus.req_a     = ~a;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, ".bp_v"}, bus.rsp_valid, 1);
                chk({tag, ".bp_rdy"}, bus.req_ready, 0);
                chk({tag, ".bp_res"}, bus.rsp_result, er);
                chk({tag, ".bp_flg"}, {z_flag, c_flag, n_flag},
                    {m_z, m_c, m_n});
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".done"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rdy"}, bus.req_ready, 1);
        chk({tag, ".vld"}, bus.rsp_valid, 0);
        chk({tag, ".res"}, bus.rsp_result, 16'h0);
        chk({tag, ".flg"}, {z_flag, c_flag, n_flag}, 3'b000);
        chk({tag, ".alu"}, {alu_optype, alu_op, alu_acc, alu_reg, alu_cin},
            {1'b1, 4'h0, 8'h00, 8'h00, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rop;
        reset_n           = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_op        = 4'h0;
        bus.req_wide      = 1'b0;
        bus.req_use_carry = 1'b0;
        bus.req_a         = 16'h0;
        bus.req_b         = 16'h0;
        bus.rsp_ready     = 1'b1;
        m_z = 1'b0;
        m_c = 1'b0;
        m_n = 1'b0;
        #3;
        chk_reset("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run("add_n",   4'h2, 0, 0, 16'h007F, 16'h0001, 0);
        run("add_w1",  4'h2, 1, 0, 16'h00FF, 16'h0001, 0);
        run("add_w2",  4'h2, 1, 0, 16'hFFFF, 16'h0001, 0);
        run("add_uc",  4'h2, 0, 1, 16'h0001, 16'h0001, 0);
        run("cmp59",   4'hA, 0, 0, 16'h0005, 16'h0009, 0);
        run("cmp99",   4'hA, 0, 0, 16'h0009, 16'h0009, 0);
        run("add_cy",  4'h2, 0, 0, 16'h00FF, 16'h0001, 0);
        run("clr",     4'hB, 0, 0, 16'h1234, 16'h5678, 0);
        run("sub",     4'h3, 0, 0, 16'h0003, 16'h0005, 0);
        run("popcnt",  4'h9, 0, 0, 16'h0000, 16'h00F3, 0);
        run("xor_w",   4'h8, 1, 0, 16'hA55A, 16'hFFFF, 0);
        run("shl_w",   4'h4, 1, 0, 16'h0081, 16'h0001, 0);
        run("bp",      4'h2, 1, 0, 16'h1234, 16'h4321, 3);
        run("add_w3",  4'h2, 1, 0, 16'hFFFF, 16'h0001, 0);

        bus.req_op        = 4'h2;
        bus.req_wide      = 1'b1;
        bus.req_use_carry = 1'b1;
        bus.req_a         = 16'h1234;
        bus.req_b         = 16'h1111;
        bus.req_valid     = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("hi.alu", {alu_optype, alu_op, alu_acc}, {1'b0, 4'h2, 8'h12});
        reset_n = 1'b0;
        #1;
        chk_reset("midhi");
        @(negedge clk);
        reset_n = 1'b1;
        m_z = 1'b0;
        m_c = 1'b0;
        m_n = 1'b0;
        run("post_rst", 4'h2, 1, 1, 16'h00FF, 16'h0001, 0);

        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(2, 11));
            run("rnd", rop, 1'($urandom), 1'($urandom),
                16'($urandom), 16'($urandom),
                ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
